zc_tone_gen: RTL and testbench

//  Stimulus-side counterpart of the zero-crossing period detector.
//  - Takes a requested half-period H (samples between zero crossings).
//  - Synthesizes a signed, sine-like parabolic waveform whose sign flips exactly every H enabled cycles.
//  - Output feeds the FIR interpolator input, closing a generate -> interpolate -> measure loop.
//  - A new H is applied only at a half-cycle boundary, so crossings stay glitch-free.

---
 rtl/zc_tone_gen.sv | 103 ++++++++++
 tb/tb_zc_tone_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/zc_tone_gen.sv
// zc_tone_gen: parabolic tone generator whose sign flips every H enabled samples
//   clk, reset          rising-edge clock, synchronous active-high reset
//   en                  sample enable; low freezes waveform state and outputs
//   period_in/valid     requested half-period H (values below 2 become 2)
//   period_ready        1-deep pending register is empty
//   y                   signed sample, +/-((k+1)*(H-k)) << GAIN_SHIFT
//   zc                  high on the first sample of each half-cycle
//   running             high once the first period has been accepted
module zc_tone_gen #(
    parameter int CNT_W      = 10,
    parameter int GAIN_SHIFT = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [CNT_W-1:0]    period_in,
    input  logic                period_valid,
    output logic                period_ready,
    output logic signed [31:0]  y,
    output logic                zc,
    output logic                running
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_d;
    logic [CNT_W-1:0] h, k, pend_val, clamped, h_next;
    logic pend_v, neg, accept, boundary;
    logic [19:0] p, p_step;
    logic signed [11:0] delta;
    logic signed [31:0] y_step, y_wrap, y_first;

    function automatic logic signed [31:0] shape(input logic [19:0] v, input logic negative);
        logic signed [31:0] m;
        m = $signed(32'(v) << GAIN_SHIFT);
        return negative ? -m : m;
    endfunction

    assign period_ready = !pend_v;
    assign running      = state == RUN;
    assign accept       = period_valid && period_ready;
    assign clamped      = period_in < CNT_W'(2) ? CNT_W'(2) : period_in;
    assign boundary     = k == h - CNT_W'(1);

    always_comb begin
        state_d = (state == IDLE && accept) ? RUN : state;
        // A value accepted on the boundary edge wins over the pending one;
        // both cannot coexist since accept requires an empty pending slot.
        h_next  = accept ? clamped : (pend_v ? pend_val : h);
        // delta may be negative; 20-bit modular add is exact as p stays positive.
        p_step  = p + 20'(delta);
        y_step  = shape(p_step, neg);
        y_wrap  = shape(20'(h_next), !neg);
        y_first = shape(20'(clamped), 1'b0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            h        <= '0;
            k        <= '0;
            p        <= '0;
            delta    <= '0;
            neg      <= 1'b0;
            y        <= '0;
            zc       <= 1'b0;
            pend_v   <= 1'b0;
            pend_val <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE) begin
                if (accept) begin
                    h     <= clamped;
                    k     <= '0;
                    p     <= 20'(clamped);
                    delta <= $signed(12'(clamped) - 12'd2);
                    neg   <= 1'b0;
                    y     <= y_first;
                    zc    <= 1'b1;
                end
            end else if (en && boundary) begin
                h      <= h_next;
                k      <= '0;
                p      <= 20'(h_next);
                delta  <= $signed(12'(h_next) - 12'd2);
                neg    <= !neg;
                y      <= y_wrap;
                zc     <= 1'b1;
                pend_v <= 1'b0;
            end else begin
                if (en) begin
                    k     <= k + CNT_W'(1);
                    p     <= p_step;
                    delta <= delta - 12'sd2;
                    y     <= y_step;
                    zc    <= 1'b0;
                end
                if (accept) begin
                    pend_v   <= 1'b1;
                    pend_val <= clamped;
                end
            end
        end
    end
endmodule

// File: tb/tb_zc_tone_gen.sv
// tb_zc_tone_gen: directed self-checking bench for zc_tone_gen
module tb_zc_tone_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b1;
    logic [9:0] period_in = '0;
    logic period_valid = 1'b0;
    logic period_ready;
    logic signed [31:0] y;
    logic zc;
    logic running;
    int checks = 0;
    int errors = 0;

    zc_tone_gen #(.CNT_W(10), .GAIN_SHIFT(12)) dut (
        .clk(clk), .reset(reset), .en(en), .period_in(period_in),
        .period_valid(period_valid), .period_ready(period_ready),
        .y(y), .zc(zc), .running(running)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        period_valid = 1'b0;
        en = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic offer(input logic [9:0] v);
        period_in = v;
        period_valid = 1'b1;
        tick();
        period_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (y !== 32'sd0 || zc !== 1'b0 || running !== 1'b0 || period_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset cyc %0d: y=%0d zc=%b running=%b ready=%b, want 0 0 0 1", i, y, zc, running, period_ready);
            end
            tick();
        end
    endtask

    task automatic test_h4();
        int exp_y[16] = '{16384, 24576, 24576, 16384, -16384, -24576, -24576, -16384,
                          16384, 24576, 24576, 16384, -16384, -24576, -24576, -16384};
        do_reset();
        offer(10'd4);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (y !== exp_y[i] || zc !== (i % 4 == 0) || running !== 1'b1) begin
                errors++;
                $display("FAIL h4 sample %0d: y=%0d zc=%b running=%b, want y=%0d zc=%b running=1", i, y, zc, running, exp_y[i], i % 4 == 0);
            end
            tick();
        end
    endtask

    task automatic test_h1023();
        longint e;
        int kk;
        do_reset();
        offer(10'd1023);
        for (int n = 0; n < 2046; n++) begin
            kk = n % 1023;
            e = longint'(kk + 1) * longint'(1023 - kk) * 4096;
            if (n >= 1023) e = -e;
            checks++;
            if (longint'(y) !== e || zc !== (kk == 0)) begin
                errors++;
                $display("FAIL h1023 sample %0d: y=%0d zc=%b, want y=%0d zc=%b", n, y, zc, e, kk == 0);
            end
            if (n == 511) begin
                checks++;
                if (y !== 32'sd1073741824) begin
                    errors++;
                    $display("FAIL h1023 peak: y=%0d, want 1073741824", y);
                end
            end
            tick();
        end
    endtask

    task automatic test_pending();
        int exp_y[7] = '{-24576, -40960, -49152, -49152, -40960, -24576, 24576};
        do_reset();
        offer(10'd4);
        tick();
        checks++;
        if (y !== 32'sd24576 || period_ready !== 1'b1) begin
            errors++;
            $display("FAIL pend k1: y=%0d ready=%b, want 24576 1", y, period_ready);
        end
        offer(10'd6);
        checks++;
        if (y !== 32'sd24576 || period_ready !== 1'b0) begin
            errors++;
            $display("FAIL pend k2: y=%0d ready=%b, want 24576 0", y, period_ready);
        end
        offer(10'd9);
        checks++;
        if (y !== 32'sd16384 || period_ready !== 1'b0) begin
            errors++;
            $display("FAIL pend k3: y=%0d ready=%b, want 16384 0", y, period_ready);
        end
        tick();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (y !== exp_y[i] || zc !== (i == 0 || i == 6) || period_ready !== 1'b1) begin
                errors++;
                $display("FAIL pend next half %0d: y=%0d zc=%b ready=%b, want y=%0d zc=%b ready=1", i, y, zc, period_ready, exp_y[i], i == 0 || i == 6);
            end
            tick();
        end
    endtask

    task automatic test_clamp();
        int exp_y[5] = '{8192, 8192, -8192, -8192, 8192};
        logic [9:0] req[2] = '{10'd0, 10'd1};
        for (int r = 0; r < 2; r++) begin
            do_reset();
            offer(req[r]);
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (y !== exp_y[i] || zc !== (i % 2 == 0)) begin
                    errors++;
                    $display("FAIL clamp H=%0d sample %0d: y=%0d zc=%b, want y=%0d zc=%b", req[r], i, y, zc, exp_y[i], i % 2 == 0);
                end
                tick();
            end
        end
    endtask

    task automatic test_enable_and_reset();
        int exp_y[4] = '{24576, 24576, 16384, -16384};
        do_reset();
        offer(10'd4);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (y !== 32'sd16384 || zc !== 1'b1) begin
                errors++;
                $display("FAIL freeze cyc %0d: y=%0d zc=%b, want 16384 1", i, y, zc);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (y !== exp_y[i] || zc !== (i == 3)) begin
                errors++;
                $display("FAIL resume %0d: y=%0d zc=%b, want y=%0d zc=%b", i, y, zc, exp_y[i], i == 3);
            end
        end
        offer(10'd6);
        checks++;
        if (period_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre-reset pending: ready=%b, want 0", period_ready);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (y !== 32'sd0 || zc !== 1'b0 || running !== 1'b0 || period_ready !== 1'b1) begin
                errors++;
                $display("FAIL midrun reset cyc %0d: y=%0d zc=%b running=%b ready=%b, want 0 0 0 1", i, y, zc, running, period_ready);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_h4();
        test_h1023();
        test_pending();
        test_clamp();
        test_enable_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
